// File: rtl/booth_mul_seq.sv
// booth_mul_seq: radix-2 Booth sequential multiplier with valid/ready handshakes.
//
// Operands are widened by one guard bit (IW = WIDTH+1) so one datapath handles both
// signed and unsigned requests. One Booth step runs per cycle for IW cycles. The
// product is then held in a register until the consumer takes it.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   flush             synchronous abort of any transaction in flight
//   in_valid/in_ready operand handshake; in_signed selects two's-complement operands
//   in_a, in_b        multiplicand M, multiplier Q (WIDTH bits)
//   out_valid/out_ready product handshake; out_product is 2*WIDTH bits, held while valid
//   busy              high while iterating
module booth_mul_seq #(
   parameter int unsigned WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_product,
   output logic               busy
);

   localparam int unsigned IW    = WIDTH + 1;
   localparam int unsigned CNT_W = $clog2(IW + 1);

   localparam logic [CNT_W-1:0] CntLoad = CNT_W'(IW);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(1);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StCalc = 2'd1,
      StDone = 2'd2
   } state_e;

   state_e           state;
   logic [IW-1:0]    acc;      // A
   logic [IW-1:0]    mcand;    // M
   logic [IW-1:0]    mplier;   // Q
   logic             q_m1;     // Q_-1
   logic [CNT_W-1:0] cnt;

   logic [IW-1:0]    acc_sum;
   logic [2*IW-1:0]  aq_shift;
   logic [IW-1:0]    a_ext;
   logic [IW-1:0]    b_ext;

   // Guard bit: copy of the sign bit for signed requests, zero for unsigned.
   assign a_ext = {in_signed & in_a[WIDTH-1], in_a};
   assign b_ext = {in_signed & in_b[WIDTH-1], in_b};

   always_comb begin
      acc_sum = acc;
      case ({mplier[0], q_m1})
         2'b10:   acc_sum = acc - mcand;
         2'b01:   acc_sum = acc + mcand;
         default: acc_sum = acc;
      endcase
   end

   // Arithmetic right shift of {A, Q}; the bit shifted out of Q becomes the new Q_-1.
   assign aq_shift = {acc_sum[IW-1], acc_sum, mplier[IW-1:1]};

   assign in_ready = (state == StIdle) && !rst;
   assign busy     = (state == StCalc);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= StIdle;
         acc         <= '0;
         mcand       <= '0;
         mplier      <= '0;
         q_m1        <= 1'b0;
         cnt         <= '0;
         out_valid   <= 1'b0;
         out_product <= '0;
      end else if (flush) begin
         // Drops pending operands and any undelivered product.
         state     <= StIdle;
         out_valid <= 1'b0;
      end else begin
         case (state)
            StIdle: begin
               if (in_valid) begin
                  mcand  <= a_ext;
                  mplier <= b_ext;
                  acc    <= '0;
                  q_m1   <= 1'b0;
                  cnt    <= CntLoad;
                  state  <= StCalc;
               end
            end
            StCalc: begin
               acc    <= aq_shift[2*IW-1:IW];
               mplier <= aq_shift[IW-1:0];
               q_m1   <= mplier[0];
               cnt    <= cnt - 1'b1;
               if (cnt == CntLast) begin
                  out_product <= aq_shift[2*WIDTH-1:0];
                  out_valid   <= 1'b1;
                  state       <= StDone;
               end
            end
            StDone: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= StIdle;
               end
            end
            default: begin
               out_valid <= 1'b0;
               state     <= StIdle;
            end
         endcase
      end
   end

endmodule
